// File: rtl/fifo_bit_serializer.sv
// fifo_bit_serializer: pops one word at a time from a FIFO read port and
// shifts it out bit-serially on a valid/ready link, flagging the last bit of
// each word and counting completed words.
module fifo_bit_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic                  ser_ready,
  output logic                  ser_valid,
  output logic                  ser_bit,
  output logic                  ser_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]         bit_cnt;
  logic                  at_last;
  logic                  xfer;

  // Shift toward whichever end feeds ser_bit, back-filling with zeros.
  always_comb begin
    shreg_nxt = shreg;
    if (MSB_FIRST != 0) shreg_nxt = {shreg[DATA_WIDTH-2:0], 1'b0};
    else                shreg_nxt = {1'b0, shreg[DATA_WIDTH-1:1]};
  end

  assign at_last = (bit_cnt == LAST_IDX);
  assign xfer    = ser_valid & ser_ready;

  // Outputs decode registered state only; ser_bit/ser_last are gated so they
  // read 0 outside SHIFT.
  assign ser_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign ser_last  = (state == SHIFT) & at_last;
  assign ser_bit   = (state == SHIFT) &
                     ((MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0]);

  // Control FSM: capture a word in IDLE, stream it in SHIFT; fifo_rd pulses
  // in the first SHIFT cycle so the FIFO pops at the end of that cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      fifo_rd    <= 1'b0;
      words_sent <= '0;
    end else begin
      fifo_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shreg   <= fifo_dout;
            bit_cnt <= '0;
            fifo_rd <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (at_last) begin
              state      <= IDLE;
              words_sent <= words_sent + CNT_WIDTH'(1);
            end else begin
              shreg   <= shreg_nxt;
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_bit_serializer.sv
// Bench for fifo_bit_serializer: two instances (LSB-first/16-bit count and
// MSB-first/2-bit count) share one FIFO model and ready line. A transaction
// model expands each popped word into its expected bit stream per instance.
module tb_fifo_bit_serializer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        ser_ready = 1'b0;

  logic        rd_a, v_a, b_a, l_a, busy_a;
  logic [15:0] ws_a;
  logic        rd_b, v_b, b_b, l_b, busy_b;
  logic [1:0]  ws_b;

  fifo_bit_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .CNT_WIDTH(16)) u_a (
    .clk(clk), .resetn(resetn), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd(rd_a), .ser_ready(ser_ready), .ser_valid(v_a), .ser_bit(b_a),
    .ser_last(l_a), .busy(busy_a), .words_sent(ws_a));

  fifo_bit_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1), .CNT_WIDTH(2)) u_b (
    .clk(clk), .resetn(resetn), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd(rd_b), .ser_ready(ser_ready), .ser_valid(v_b), .ser_bit(b_b),
    .ser_last(l_b), .busy(busy_b), .words_sent(ws_b));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] fq[$];      // FIFO contents, head = fq[0]
  logic       expa[$];    // expected remaining bits, LSB-first instance
  logic       expb[$];    // expected remaining bits, MSB-first instance
  int         ws_exp = 0; // words completed since last reset

  logic obs_rd, obs_v, obs_xfer, obs_bit_a, obs_bit_b;

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    refresh();
  endtask

  // Sample outputs for the current cycle and score them against the model.
  task automatic monitor();
    logic [7:0] w;
    logic       last_exp;
    obs_rd = rd_a; obs_v = v_a; obs_xfer = 1'b0;
    obs_bit_a = b_a; obs_bit_b = b_b;
    if (!resetn) begin
      if (rd_a) w = fq.pop_front();
      expa.delete(); expb.delete(); ws_exp = 0;
      return;
    end
    checks++;
    if (rd_a !== rd_b || v_a !== v_b || busy_a !== v_a || busy_b !== v_b) begin
      failures++;
      $display("FAIL lockstep: rd=%b/%b valid=%b/%b busy=%b/%b", rd_a, rd_b, v_a, v_b, busy_a, busy_b);
    end
    checks++;
    if (ws_a !== 16'(ws_exp) || ws_b !== 2'(ws_exp)) begin
      failures++;
      $display("FAIL words_sent: got %0d/%0d want %0d/%0d", ws_a, ws_b, 16'(ws_exp), 2'(ws_exp));
    end
    if (rd_a) begin
      checks++;
      if (expa.size() != 0 || fq.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: pending=%0d fifo=%0d want 0/>0", expa.size(), fq.size());
      end
      if (fq.size() != 0) begin
        w = fq.pop_front();
        for (int i = 0; i < 8; i++) begin
          expa.push_back(w[i]);
          expb.push_back(w[7-i]);
        end
      end
    end
    if (!v_a) begin
      checks++;
      if (expa.size() != 0 || l_a !== 1'b0 || l_b !== 1'b0) begin
        failures++;
        $display("FAIL idle_state: pending=%0d last=%b/%b want 0/0/0", expa.size(), l_a, l_b);
      end
    end else begin
      checks++;
      if (expa.size() == 0) begin
        failures++;
        $display("FAIL valid_unexpected: valid=%b want 0", v_a);
      end else begin
        last_exp = (expa.size() == 1);
        if (b_a !== expa[0] || b_b !== expb[0] || l_a !== last_exp || l_b !== last_exp) begin
          failures++;
          $display("FAIL bit_stream: bit=%b/%b last=%b/%b want bit=%b/%b last=%b",
                   b_a, b_b, l_a, l_b, expa[0], expb[0], last_exp);
        end
        if (ser_ready) begin
          obs_xfer = 1'b1;
          void'(expa.pop_front());
          void'(expb.pop_front());
          if (last_exp) ws_exp++;
        end
      end
    end
  endtask

  // One clock: drive ready/reset for the coming edge, score, update FIFO view.
  task automatic step(input logic rdy, input logic rn);
    @(negedge clk);
    ser_ready = rdy;
    resetn    = rn;
    monitor();
    refresh();
  endtask

  task automatic drain();
    int n = 0;
    while ((fq.size() != 0 || expa.size() != 0 || v_a) && n < 300) begin
      step(1'b1, 1'b1);
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL drain_timeout: fifo=%0d pending=%0d valid=%b", fq.size(), expa.size(), v_a);
    end
  endtask

  // Run one word with a per-cycle ready pattern; collect bits in send order.
  task automatic run_word(input logic [12:0] pat, output logic first_ok,
                          output int nv, output int nrd,
                          output logic [7:0] wa, output logic [7:0] wb);
    int idx = 0;
    int k = 0;
    nv = 0; nrd = 0; wa = 8'h00; wb = 8'h00; first_ok = 1'b0;
    do begin
      step((k < 13) ? pat[k] : 1'b1, 1'b1);
      if (k == 0) first_ok = obs_rd & obs_v;
      if (obs_rd) nrd++;
      if (obs_v) nv++;
      if (obs_xfer && idx < 8) begin
        wa[idx] = obs_bit_a;
        wb[7-idx] = obs_bit_b;
        idx++;
      end
      k++;
    end while (obs_v && k < 40);
  endtask

  task automatic check_word(input string name, input logic first_ok, input int nv,
                            input int nrd, input logic [7:0] wa, input logic [7:0] wb,
                            input int nv_exp, input logic [7:0] w_exp);
    checks++;
    if (first_ok !== 1'b1) begin
      failures++;
      $display("FAIL %s_latency: rd&valid in first cycle=%b want 1", name, first_ok);
    end
    checks++;
    if (nv != nv_exp || nrd != 1) begin
      failures++;
      $display("FAIL %s_cycles: shift=%0d rd=%0d want %0d/1", name, nv, nrd, nv_exp);
    end
    checks++;
    if (wa !== w_exp || wb !== w_exp) begin
      failures++;
      $display("FAIL %s_data: lsb=%h msb=%h want %h", name, wa, wb, w_exp);
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if ({rd_a, v_a, b_a, l_a, busy_a} !== 5'b0 || ws_a !== 16'd0) begin
      failures++;
      $display("FAIL reset_a: rd/v/bit/last/busy=%b ws=%0d want 00000/0", {rd_a, v_a, b_a, l_a, busy_a}, ws_a);
    end
    checks++;
    if ({rd_b, v_b, b_b, l_b, busy_b} !== 5'b0 || ws_b !== 2'd0) begin
      failures++;
      $display("FAIL reset_b: rd/v/bit/last/busy=%b ws=%0d want 00000/0", {rd_b, v_b, b_b, l_b, busy_b}, ws_b);
    end
    step(1'b1, 1'b1);
  endtask

  task automatic test_single();
    logic f; int nv, nrd; logic [7:0] wa, wb; logic [15:0] ws0;
    ws0 = ws_a;
    push(8'h80);
    run_word(13'h1FFF, f, nv, nrd, wa, wb);
    check_word("single", f, nv, nrd, wa, wb, 8, 8'h80);
    checks++;
    if (ws_a !== ws0 + 16'd1 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL single_count: ws=%0d busy=%b want %0d/0", ws_a, busy_a, ws0 + 16'd1);
    end
  endtask

  task automatic test_backpressure();
    logic f; int nv, nrd; logic [7:0] wa, wb;
    push(8'h5A);
    run_word(13'b1001111100011, f, nv, nrd, wa, wb);
    check_word("backpressure", f, nv, nrd, wa, wb, 13, 8'h5A);
  endtask

  task automatic test_back_to_back();
    logic [17:0] vh, rh; logic [15:0] ws0;
    ws0 = ws_a;
    push(8'h3C);
    push(8'hFF);
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b1);
      vh[i] = obs_v;
      rh[i] = obs_rd;
    end
    checks++;
    if (vh !== 18'h1FEFF || rh !== 18'h00201) begin
      failures++;
      $display("FAIL back_to_back: valid=%b rd=%b want %b/%b", vh, rh, 18'h1FEFF, 18'h00201);
    end
    checks++;
    if (ws_a !== ws0 + 16'd2) begin
      failures++;
      $display("FAIL back_to_back_count: ws=%0d want %0d", ws_a, ws0 + 16'd2);
    end
  endtask

  task automatic test_reset_mid_word();
    push(8'hA5);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1); // pop cycle + 4 transfers
    step(1'b1, 1'b0);
    push(8'hC3);
    step(1'b1, 1'b1);
    checks++;
    if (v_a !== 1'b0 || busy_a !== 1'b0 || ws_a !== 16'd0 || ws_b !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid: valid=%b busy=%b ws=%0d/%0d want 0/0/0/0", v_a, busy_a, ws_a, ws_b);
    end
    step(1'b1, 1'b1);
    checks++;
    if (obs_rd !== 1'b1 || obs_v !== 1'b1) begin
      failures++;
      $display("FAIL reset_restart: rd=%b valid=%b want 1/1", obs_rd, obs_v);
    end
    drain();
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) push(8'($urandom));
    drain();
    checks++;
    if (ws_b !== 2'd1 || ws_a !== 16'd5) begin
      failures++;
      $display("FAIL wrap: ws_b=%0d ws_a=%0d want 1/5", ws_b, ws_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (fq.size() < 2 && $urandom_range(0, 3) == 0) push(8'($urandom));
      step($urandom_range(0, 3) != 0, 1'b1);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
